multicyclecontrol: RTL
======================

# multicyclecontrol

Sequencing controller for the multicycle variant of the processor. The datapath shares one memory between instruction fetch and data access, and one ALU between PC increment, branch target, address and arithmetic. This block is a Moore-style FSM, gated by a memory-ready handshake. It decodes the 6-bit opcode and drives every datapath select/enable per cycle. It also emits a retire pulse and a 32-bit retired-instruction counter for debug.

## Interface
- No parameters; all encodings come from the shared package.
- clock  in  1  sole clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- opcode  in  6  instruction bits [31:26], taken from the instruction register
- memready  in  1  memory has completed the current read/write this cycle
- pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst  out  1 each  datapath enables/selects
- pcsource  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- alusrcb  out  2  00 regB, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
- aluop  out  2  00 add, 01 subtract, 10 funct-decoded (to existing alucontrol)
- state  out  4  current state encoding (debug)
- instdone  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE on unsupported opcode
- instcount  out  32  retired-instruction count

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States (4-bit): FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, RCOMPLETE 7, BRANCH 8, JUMP 9, ADDIEXEC 10, ADDIWB 11. Codes 12-15 are unreachable and go to FETCH.
- All outputs not listed for a state are 0.
- FETCH
  - Outputs: memread=1, alusrcb=01.
  - irwrite=1 and pcwrite=1 only when memready=1.
  - Holds while memready=0, otherwise goes to DECODE.
- DECODE
  - Outputs: alusrcb=11.
  - Next state: R→EXECUTE, lw/sw→MEMADDR, beq→BRANCH, j→JUMP, addi→ADDIEXEC.
  - Any other opcode→FETCH, with illegal=1.
- MEMADDR
  - Outputs: alusrca=1, alusrcb=10.
  - lw→MEMREAD, sw→MEMWRITE.
- MEMREAD
  - Outputs: memread=1, iord=1.
  - Holds until memready, then goes to MEMWB.
- MEMWB
  - Outputs: regwrite=1, memtoreg=1.
  - Goes to FETCH.
- MEMWRITE
  - Outputs: memwrite=1, iord=1.
  - Holds until memready, then goes to FETCH.
- EXECUTE
  - Outputs: alusrca=1, aluop=10.
  - Goes to RCOMPLETE.
- RCOMPLETE
  - Outputs: regdst=1, regwrite=1.
  - Goes to FETCH.
- BRANCH
  - Outputs: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - Goes to FETCH.
- JUMP
  - Outputs: pcwrite=1, pcsource=10.
  - Goes to FETCH.
- ADDIEXEC
  - Outputs: alusrca=1, alusrcb=10.
  - Goes to ADDIWB.
- ADDIWB
  - Outputs: regwrite=1.
  - Goes to FETCH.
- opcode is re-sampled in MEMADDR, so the datapath must hold the IR stable for the whole instruction.
- instdone=1 in MEMWB, RCOMPLETE, BRANCH, JUMP and ADDIWB, and in MEMWRITE when memready=1.
- instcount increments by 1 on every edge where instdone=1. It wraps 0xFFFFFFFF→0 without a flag.

## Timing
- Reset:
  - While reset=1, all outputs are forced to 0 combinationally.
  - On the reset edge: state←FETCH, instcount←0.
  - Reset mid-instruction abandons it: no instcount increment, even if instdone was due that cycle.
- Cycles with memready held at 1: R 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2 (no retire).
- Each memready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay stable during the wait, apart from the memready-gated irwrite/pcwrite in FETCH.
- memready is ignored in every other state.
- The first FETCH after reset deassertion begins on the next cycle.

## Structure
- Shared package holds:
  - state encodings
  - opcode constants
  - aluop codes (ADD, SUB, FUNCT)
  - alusrcb codes (REGB, FOUR, IMM, IMMSHIFT)
  - pcsource codes
- One module, no sub-modules.
- Three parts: state register plus counter, next-state logic, output decode. The output decode also feeds the existing alucontrol and the muxes.

## Test plan
- Reset with opcode=000000 held and memready=1: all outputs 0 during reset. Then the state sequence is 0,1,6,7,0; instdone pulses in state 7; instcount=1.
- lw with memready low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - takes 10 cycles;
  - irwrite and pcwrite pulse only once;
  - memtoreg=1 and regwrite=1 in state 4.
- sw with memready=0 for 1 cycle in MEMWRITE: memwrite=1 held for 2 cycles, iord=1; instdone only on the memready cycle.
- beq then j back-to-back: in BRANCH, pcwritecond=1, pcsource=01, aluop=01; in JUMP, pcwrite=1, pcsource=10. instcount advances by 2 in 6 cycles.
- opcode=111111: illegal pulses in DECODE and the FSM returns to FETCH; instcount is unchanged.
- instcount preloaded near wrap via 0xFFFFFFFF retirements (force) → next retire gives 0. Reset asserted in MEMREAD gives state 0 and instcount 0.

Source files
------------

// File: rtl/multicyclecontrol_pkg.sv
// Shared encodings for the multicycle sequencing controller: states, opcodes,
// and the select codes driven into the shared ALU, its muxes and the PC mux.
package multicyclecontrol_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE   = 4'd6,
    S_RCOMPLETE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDIEXEC  = 4'd10,
    S_ADDIWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB     = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMMSHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Per-cycle datapath control word produced by the output decode.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instdone;
    logic       illegal;
  } ctl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicyclecontrol.sv
// Moore sequencing FSM for the multicycle processor: state register and
// retire counter, next-state logic gated by memready, and per-state output decode.
module multicyclecontrol
  import multicyclecontrol_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        memready,
  output logic        pcwrite,
  output logic        pcwritecond,
  output logic        iord,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        irwrite,
  output logic        alusrca,
  output logic        regwrite,
  output logic        regdst,
  output logic [1:0]  pcsource,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic [3:0]  state,
  output logic        instdone,
  output logic        illegal,
  output logic [31:0] instcount
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] count_q;
  ctl_t        ctl;

  // State register and retire counter; reset drops any pending retirement.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (ctl.instdone) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (memready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      // The opcode is looked at again here, so the IR must stay stable.
      S_MEMADDR: begin
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD: begin
        if (memready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (memready) state_d = S_FETCH;
      end
      S_EXECUTE:   state_d = S_RCOMPLETE;
      S_ADDIEXEC:  state_d = S_ADDIWB;
      S_MEMWB, S_RCOMPLETE, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.memread = 1'b1;
        ctl.alusrcb = SRCB_FOUR;
        ctl.irwrite = memready;
        ctl.pcwrite = memready;
      end
      S_DECODE: begin
        ctl.alusrcb = SRCB_IMMSHIFT;
        ctl.illegal = ~is_supported(opcode);
      end
      S_MEMADDR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctl.memread = 1'b1;
        ctl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
        ctl.instdone = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.memwrite = 1'b1;
        ctl.iord     = 1'b1;
        ctl.instdone = memready;
      end
      S_EXECUTE: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALUOP_FUNCT;
      end
      S_RCOMPLETE: begin
        ctl.regdst   = 1'b1;
        ctl.regwrite = 1'b1;
        ctl.instdone = 1'b1;
      end
      S_BRANCH: begin
        ctl.alusrca     = 1'b1;
        ctl.aluop       = ALUOP_SUB;
        ctl.pcwritecond = 1'b1;
        ctl.pcsource    = PCSRC_ALUOUT;
        ctl.instdone    = 1'b1;
      end
      S_JUMP: begin
        ctl.pcwrite  = 1'b1;
        ctl.pcsource = PCSRC_JUMP;
        ctl.instdone = 1'b1;
      end
      S_ADDIEXEC: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctl.regwrite = 1'b1;
        ctl.instdone = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Every output is held at zero while reset is asserted.
  assign pcwrite     = ctl.pcwrite     & ~reset;
  assign pcwritecond = ctl.pcwritecond & ~reset;
  assign iord        = ctl.iord        & ~reset;
  assign memread     = ctl.memread     & ~reset;
  assign memwrite    = ctl.memwrite    & ~reset;
  assign memtoreg    = ctl.memtoreg    & ~reset;
  assign irwrite     = ctl.irwrite     & ~reset;
  assign alusrca     = ctl.alusrca     & ~reset;
  assign regwrite    = ctl.regwrite    & ~reset;
  assign regdst      = ctl.regdst      & ~reset;
  assign instdone    = ctl.instdone    & ~reset;
  assign illegal     = ctl.illegal     & ~reset;
  assign pcsource    = reset ? 2'b00 : ctl.pcsource;
  assign alusrcb     = reset ? 2'b00 : ctl.alusrcb;
  assign aluop       = reset ? 2'b00 : ctl.aluop;
  assign state       = reset ? 4'd0  : state_q;
  assign instcount   = reset ? 32'd0 : count_q;

endmodule
